alu_share_ctrl: RTL and testbench

Shared-ALU arbiter and sequencer for the processor datapath. Two requesters (port 0: core execute stage, port 1: auxiliary unit) submit ALU operations over valid/ready handshakes; the block grants one requester at a time round-robin, executes the operation on one internal N-bit ALU, and returns the result and (Z)(N)(C)(V) flags on a single response channel tagged with the requester ID. One operation is in flight at a time.

---
 rtl/alu_share_ctrl.sv | 77 +++++++
 tb/tb_alu_share_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin arbiter sharing one N-bit ALU between two requesters.
// One operation in flight: IDLE grants, EXEC computes into rsp regs, RESP holds until consumed.
module alu_share_ctrl #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_result,
  output logic [3:0]   rsp_flags
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic last_grant, gnt1, acc, id_q, arith, c, v;
  logic [2:0] op_q;
  logic [N-1:0] a_q, b_q, res;
  logic [N:0] sum;
  always_comb begin
    gnt1 = req1_valid & (~req0_valid | ~last_grant);
    acc = (state == IDLE) & (req0_valid | req1_valid);
    req0_ready = acc & ~gnt1;
    req1_ready = acc & gnt1;
    rsp_valid = state == RESP;
    state_nx = state == IDLE ? (acc ? EXEC : IDLE) :
               state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
  end
  // SUB is a + ~b + 1, so the carry out is the "no borrow" flag directly
  always_comb begin
    arith = op_q[2:1] == 2'b00;
    sum = op_q[0] ? {1'b0, a_q} + {1'b0, ~b_q} + (N+1)'(1) : {1'b0, a_q} + {1'b0, b_q};
    res = arith ? sum[N-1:0] :
          op_q == 3'd2 ? a_q & b_q :
          op_q == 3'd3 ? a_q | b_q :
          op_q == 3'd4 ? a_q ^ b_q : '0;
    c = arith & sum[N];
    v = arith & (a_q[N-1] ^ b_q[N-1] ^ ~op_q[0]) & (sum[N-1] ^ a_q[N-1]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
      id_q <= 1'b0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      rsp_id <= 1'b0;
      rsp_result <= '0;
      rsp_flags <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        last_grant <= gnt1;
        id_q <= gnt1;
        op_q <= gnt1 ? req1_op : req0_op;
        a_q <= gnt1 ? req1_a : req0_a;
        b_q <= gnt1 ? req1_b : req0_b;
      end
      if (state == EXEC) begin
        rsp_id <= id_q;
        rsp_result <= res;
        rsp_flags <= {res == '0, res[N-1], c, v};
      end
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed stimulus plus a cycle-level reference model checked every negedge.
module tb_alu_share_ctrl;
  logic clk = 0, rst_n = 1;
  logic req0_valid = 0, req1_valid = 0, rsp_ready = 1;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [31:0] rsp_result;
  logic [3:0] rsp_flags;
  int total = 0, bad = 0;

  alu_share_ctrl #(.N(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference arithmetic with wide signed/unsigned integers; returns {flags, result}
  function automatic logic [35:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, sv;
    logic [31:0] r;
    logic c, v;
    ua = longint'(a); ub = longint'(b);
    sa = longint'($signed(a)); sb = longint'($signed(b));
    r = 0; c = 0; v = 0;
    case (op)
      3'd0: begin
        r = a + b; c = (ua + ub) >= 64'sd4294967296; sv = sa + sb;
        v = sv > 64'sd2147483647 || sv < -64'sd2147483648;
      end
      3'd1: begin
        r = a - b; c = ua >= ub; sv = sa - sb;
        v = sv > 64'sd2147483647 || sv < -64'sd2147483648;
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      default: r = 0;
    endcase
    return {r == 0, r[31], c, v, r};
  endfunction

  // model: phase 0 waiting for grant, 1 computing, 2 response offered
  int m_phase = 0;
  bit m_last = 1, m_id = 0, w;
  logic [35:0] m_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_last = 1;
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_rsp", {rsp_id, rsp_flags, rsp_result}, 0);
    end else if (m_phase == 0) begin
      w = (req0_valid && req1_valid) ? !m_last : req1_valid;
      chk("ready0", req0_ready, req0_valid && (w == 0));
      chk("ready1", req1_ready, req1_valid && (w == 1));
      chk("idle_valid", rsp_valid, 0);
      if (req0_valid || req1_valid) begin
        m_last = w; m_id = w; m_phase = 1;
        m_exp = w ? alu_ref(req1_op, req1_a, req1_b) : alu_ref(req0_op, req0_a, req0_b);
      end
    end else begin
      chk("busy_ready", {req0_ready, req1_ready}, 0);
      chk("rsp_valid", rsp_valid, m_phase == 2);
      if (m_phase == 2) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_data", {rsp_flags, rsp_result}, m_exp);
        if (rsp_ready) m_phase = 0;
      end else m_phase = 2;
    end
  end

  task automatic do_op(input bit p, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef);
    int n;
    bit got;
    if (p) begin req1_op = op; req1_a = a; req1_b = b; req1_valid = 1; end
    else begin req0_op = op; req0_a = a; req0_b = b; req0_valid = 1; end
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = p ? req1_ready : req0_ready;
    end
    chk("grant_timeout", got, 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    got = 0; n = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      got = rsp_valid; n = i;
    end
    chk("rsp_latency", n, 2);
    chk("op_id", rsp_id, p);
    chk("op_result", rsp_result, er);
    chk("op_flags", rsp_flags, ef);
    @(posedge clk); #1;
  endtask

  initial begin
    int g[$], t[$];
    bit got;
    logic [36:0] snap;
    chk("ref_add", alu_ref(0, 32'h7FFFFFFF, 1), {4'b0101, 32'h80000000});
    chk("ref_sub0", alu_ref(1, 5, 5), {4'b1010, 32'h0});
    chk("ref_subb", alu_ref(1, 0, 1), {4'b0100, 32'hFFFFFFFF});
    chk("ref_rsv", alu_ref(7, 9, 9), {4'b1000, 32'h0});
    #1 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    do_op(0, 3'd0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 4'b0101);
    do_op(1, 3'd1, 32'h5, 32'h5, 32'h0, 4'b1010);
    do_op(1, 3'd1, 32'h0, 32'h1, 32'hFFFFFFFF, 4'b0100);
    do_op(0, 3'd4, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 4'b1000);
    do_op(0, 3'd7, 32'h1234, 32'h5678, 32'h0, 4'b1000);
    // contention: last grant was port 0, so port 1 goes first
    req0_op = 3'd2; req0_a = 32'hF0F0F0F0; req0_b = 32'hFF00FF00;
    req1_op = 3'd3; req1_a = 32'h0F0F0000; req1_b = 32'h000000FF;
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin g.push_back(int'(req1_ready)); t.push_back(i); end
    end
    chk("rr_count", g.size(), 4);
    for (int k = 0; k < g.size(); k++) begin
      chk("rr_grant", g[k], (k % 2 == 0) ? 1 : 0);
      if (k > 0) chk("rr_interval", t[k] - t[k-1], 3);
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    // back-pressure with both requesters waiting
    rsp_ready = 0; req0_op = 3'd0; req0_a = 3; req0_b = 4; req1_op = 3'd1; req1_a = 10; req1_b = 3;
    req0_valid = 1; req1_valid = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = rsp_valid; end
    chk("bp_timeout", got, 1);
    snap = {rsp_id, rsp_flags, rsp_result};
    repeat (5) begin
      @(negedge clk);
      chk("bp_stable", {rsp_valid, rsp_id, rsp_flags, rsp_result}, {1'b1, snap});
      chk("bp_ready", {req0_ready, req1_ready}, 0);
    end
    @(posedge clk); #1 rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_regrant", req0_ready | req1_ready, 1);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    // reset while an operation is in EXEC
    req0_op = 3'd0; req0_a = 32'h11; req0_b = 32'h22; req0_valid = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = req0_ready; end
    chk("rst_grant_timeout", got, 1);
    @(posedge clk); #1;
    req0_valid = 0; rst_n = 0;
    #1;
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_rsp", {rsp_id, rsp_flags, rsp_result}, 0);
    @(posedge clk); #1 rst_n = 1;
    repeat (2) @(negedge clk);
    chk("rst_no_stale", rsp_valid, 0);
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("rst_first_win", {req0_ready, req1_ready}, 2'b10);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    repeat (4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
